multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset main control FSM
// State register plus state-decoded control outputs; illegal and branch pc_write are same-cycle.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t cur;
    logic   mem_is_lw;
    logic   op_ok;
    logic   fn_ok;
    logic [3:0] fn_alu;

    assign state = cur;

    always_comb begin
        op_ok = 1'b1;
        case (opcode)
            OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_J, OP_ADDI: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        fn_ok  = 1'b1;
        fn_alu = ALU_ADD;
        case (funct)
            6'b100000: fn_alu = ALU_ADD;
            6'b100010: fn_alu = ALU_SUB;
            6'b100100: fn_alu = ALU_AND;
            6'b100101: fn_alu = ALU_OR;
            6'b101010: fn_alu = ALU_SLT;
            default:   fn_ok  = 1'b0;
        endcase
    end

    // lw/sw is remembered at DECODE so MEMADR never looks at opcode again
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= FETCH;
            mem_is_lw <= 1'b0;
        end else begin
            case (cur)
                FETCH:  cur <= DECODE;
                DECODE: begin
                    mem_is_lw <= (opcode == OP_LW);
                    case (opcode)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYP:      cur <= EXEC;
                        OP_BEQ:       cur <= BRANCH;
                        OP_J:         cur <= JUMP;
                        OP_ADDI:      cur <= ADDIEX;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR: cur <= mem_is_lw ? MEMRD : MEMWR;
                MEMRD:  cur <= MEMWB;
                EXEC:   cur <= fn_ok ? ALUWB : FETCH;
                ADDIEX: cur <= ADDIWB;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_source   = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                illegal   = ~op_ok;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = fn_alu;
                illegal     = ~fn_ok;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_source   = 2'b01;
                pc_write    = zero;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
        // the reset cycle must not disturb PC, memory or registers
        if (reset) begin
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
// Expected per-cycle control words are queued as stimulus is driven, then popped and compared.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_control, state;

    int total = 0;
    int bad   = 0;
    logic [21:0] sb_q[$];

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .alu_control(alu_control), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] observed();
        return {state, pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_control, illegal};
    endfunction

    function automatic logic fn_valid(input logic [5:0] fn);
        return fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42;
    endfunction

    function automatic logic [3:0] fn_code(input logic [5:0] fn);
        case (fn)
            6'd34:   return 4'b0110;
            6'd36:   return 4'b0000;
            6'd37:   return 4'b0001;
            6'd42:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // Expected outputs for one cycle, written straight from the state table
    function automatic logic [21:0] expect_word(input logic [3:0] st, input logic [5:0] op,
                                                input logic [5:0] fn, input logic z,
                                                input logic rst);
        logic pcw, io, mr, mw, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, pcs;
        logic [3:0] alu;
        {pcw, io, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'b00; pcs = 2'b00; alu = 4'b0010;
        if (st == 4'd0) begin mr = 1; irw = 1; pcw = 1; asb = 2'b01; end
        if (st == 4'd1) begin
            asb = 2'b11;
            ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000});
        end
        if (st == 4'd2 || st == 4'd10) begin asa = 1; asb = 2'b10; end
        if (st == 4'd3) begin mr = 1; io = 1; end
        if (st == 4'd4) begin rw = 1; m2r = 1; end
        if (st == 4'd5) begin mw = 1; io = 1; end
        if (st == 4'd6) begin asa = 1; alu = fn_code(fn); ill = !fn_valid(fn); end
        if (st == 4'd7) begin rw = 1; rd = 1; end
        if (st == 4'd8) begin asa = 1; alu = 4'b0110; pcs = 2'b01; pcw = z; end
        if (st == 4'd9) begin pcw = 1; pcs = 2'b10; end
        if (st == 4'd11) rw = 1;
        if (rst) begin pcw = 0; mr = 0; mw = 0; irw = 0; rw = 0; ill = 0; end
        return {st, pcw, io, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, alu, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One instruction from FETCH; rst_at >= 0 asserts reset in that cycle and abandons the rest
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int rst_at);
        logic [3:0] seq[$];
        logic [21:0] exp;
        seq = '{4'd0, 4'd1};
        case (op)
            6'b100011: seq = {seq, 4'd2, 4'd3, 4'd4};
            6'b101011: seq = {seq, 4'd2, 4'd5};
            6'b000000: begin
                seq.push_back(4'd6);
                if (fn_valid(fn)) seq.push_back(4'd7);
            end
            6'b000100: seq.push_back(4'd8);
            6'b000010: seq.push_back(4'd9);
            6'b001000: seq = {seq, 4'd10, 4'd11};
            default: ;
        endcase
        if (rst_at >= 0) while (seq.size() > rst_at + 1) void'(seq.pop_back());
        for (int i = 0; i < seq.size(); i++) begin
            reset  = (i == rst_at);
            opcode = (seq[i] == 4'd1) ? op : 6'($urandom);
            funct  = (seq[i] == 4'd6) ? fn : 6'($urandom);
            zero   = (seq[i] == 4'd8) ? z  : 1'($urandom);
            sb_q.push_back(expect_word(seq[i], op, fn, z, reset));
            @(negedge clk);
            exp = sb_q.pop_front();
            check($sformatf("%s[%0d]", name, i), 32'(observed()), 32'(exp));
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_state", 32'(observed()), 32'(expect_word(4'd0, 6'd0, 6'd0, 1'b0, 1'b1)));
        @(posedge clk); #1;
        reset = 1'b0;

        run("lw",        6'b100011, 6'd0,      1'b0, -1);
        run("slt",       6'b000000, 6'b101010, 1'b0, -1);
        run("beq_taken", 6'b000100, 6'd0,      1'b1, -1);
        run("beq_not",   6'b000100, 6'd0,      1'b0, -1);
        run("bad_op",    6'b111111, 6'd0,      1'b0, -1);
        run("bad_fn",    6'b000000, 6'b000111, 1'b0, -1);
        run("lw_rst",    6'b100011, 6'd0,      1'b0,  3);
        run("sw",        6'b101011, 6'd0,      1'b0, -1);
        run("j",         6'b000010, 6'd0,      1'b0, -1);
        run("addi",      6'b001000, 6'd0,      1'b0, -1);
        run("add",       6'b000000, 6'b100000, 1'b0, -1);
        run("sub",       6'b000000, 6'b100010, 1'b0, -1);
        run("and",       6'b000000, 6'b100100, 1'b0, -1);
        run("or",        6'b000000, 6'b100101, 1'b0, -1);
        run("lw2",       6'b100011, 6'd0,      1'b0, -1);
        run("addi_rst",  6'b001000, 6'd0,      1'b0,  2);
        run("sw2",       6'b101011, 6'd0,      1'b0, -1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
